// File: rtl/alu_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module   : alu_arbiter_pkg
// Purpose  : Shared ALUctr codes and control-FSM state encodings for the
//            ALU and its two-requester arbiter.
// Revision : 1.0
// ============================================================================
package alu_arbiter_pkg;

    localparam int DATA_W = 32;
    localparam int CTR_W  = 4;

    localparam logic [CTR_W-1:0] c_ctr_add  = 4'b1110;
    localparam logic [CTR_W-1:0] c_ctr_sub  = 4'b0100;
    localparam logic [CTR_W-1:0] c_ctr_addu = 4'b0001;
    localparam logic [CTR_W-1:0] c_ctr_subu = 4'b0101;
    localparam logic [CTR_W-1:0] c_ctr_and  = 4'b0010;
    localparam logic [CTR_W-1:0] c_ctr_or   = 4'b0011;
    localparam logic [CTR_W-1:0] c_ctr_xor  = 4'b0111;
    localparam logic [CTR_W-1:0] c_ctr_sll  = 4'b1010;
    localparam logic [CTR_W-1:0] c_ctr_srl  = 4'b1000;
    localparam logic [CTR_W-1:0] c_ctr_sra  = 4'b1001;
    localparam logic [CTR_W-1:0] c_ctr_lui  = 4'b0110;

    localparam int ST_W = 2;
    localparam logic [ST_W-1:0] c_st_idle = 2'd0;
    localparam logic [ST_W-1:0] c_st_exec = 2'd1;
    localparam logic [ST_W-1:0] c_st_resp = 2'd2;

endpackage
`default_nettype wire

// File: rtl/alu_arbiter_alu.sv
`default_nettype none
// ============================================================================
// Module   : alu_arbiter_alu
// Purpose  : Combinational 32-bit ALU; illegal codes yield result 0 and err.
// Revision : 1.0
// ============================================================================
module alu_arbiter_alu
    import alu_arbiter_pkg::*;
(
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic [3:0]  ctr,
    output logic [31:0] result,
    output logic        zero,
    output logic        overflow,
    output logic        err
);

    logic [31:0] w_sum;
    logic [31:0] w_diff;
    logic [4:0]  w_shamt;

    assign w_sum   = a + b;
    assign w_diff  = a - b;
    assign w_shamt = a[4:0];

    always_comb begin
        result   = '0;
        overflow = 1'b0;
        err      = 1'b0;
        case (ctr)
            c_ctr_add: begin
                result   = w_sum;
                overflow = (a[31] == b[31]) && (w_sum[31] != a[31]);
            end
            c_ctr_sub: begin
                result   = w_diff;
                overflow = (a[31] != b[31]) && (w_diff[31] != a[31]);
            end
            c_ctr_addu: result = w_sum;
            c_ctr_subu: result = w_diff;
            c_ctr_and:  result = a & b;
            c_ctr_or:   result = a | b;
            c_ctr_xor:  result = a ^ b;
            // Shifts move B by the amount held in A[4:0]
            c_ctr_sll:  result = b << w_shamt;
            c_ctr_srl:  result = b >> w_shamt;
            c_ctr_sra:  result = $unsigned($signed(b) >>> w_shamt);
            c_ctr_lui:  result = {b[15:0], 16'h0000};
            default:    err    = 1'b1;
        endcase
    end

    assign zero = (result == 32'h0000_0000);

endmodule
`default_nettype wire

// File: rtl/alu_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : alu_arbiter
// Purpose  : Round-robin sharing of one ALU between two requesters, one
//            operation in flight (IDLE -> EXEC -> RESP).
// Revision : 1.0
// ============================================================================
module alu_arbiter
    import alu_arbiter_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [1:0]  req_valid,
    output logic [1:0]  req_ready,
    input  logic [31:0] req0_a,
    input  logic [31:0] req0_b,
    input  logic [3:0]  req0_ctr,
    input  logic [31:0] req1_a,
    input  logic [31:0] req1_b,
    input  logic [3:0]  req1_ctr,
    output logic [1:0]  rsp_valid,
    input  logic [1:0]  rsp_ready,
    output logic [31:0] rsp_result,
    output logic        rsp_zero,
    output logic        rsp_overflow,
    output logic        rsp_err
);

    logic [ST_W-1:0] r_state;
    logic [ST_W-1:0] w_state_nxt;
    logic            r_owner;
    logic            r_last_grant;
    logic [31:0]     r_a;
    logic [31:0]     r_b;
    logic [3:0]      r_ctr;

    logic            w_grant_any;
    logic            w_grant_id;
    logic            w_load;
    logic            w_capture;
    logic            w_release;

    logic [31:0]     w_alu_result;
    logic            w_alu_zero;
    logic            w_alu_overflow;
    logic            w_alu_err;

    alu_arbiter_alu u_alu (
        .a        (r_a),
        .b        (r_b),
        .ctr      (r_ctr),
        .result   (w_alu_result),
        .zero     (w_alu_zero),
        .overflow (w_alu_overflow),
        .err      (w_alu_err)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_grant_any = 1'b0;
        w_grant_id  = 1'b0;
        w_load      = 1'b0;
        w_capture   = 1'b0;
        w_release   = 1'b0;
        req_ready   = 2'b00;
        case (r_state)
            c_st_idle: begin
                // On a tie the requester that did not win last time goes next
                case (req_valid)
                    2'b01:   begin w_grant_any = 1'b1; w_grant_id = 1'b0;          end
                    2'b10:   begin w_grant_any = 1'b1; w_grant_id = 1'b1;          end
                    2'b11:   begin w_grant_any = 1'b1; w_grant_id = ~r_last_grant; end
                    default: begin w_grant_any = 1'b0; w_grant_id = 1'b0;          end
                endcase
                if (w_grant_any && !rst) begin
                    req_ready[w_grant_id] = 1'b1;
                    w_load                = 1'b1;
                    w_state_nxt           = c_st_exec;
                end
            end
            c_st_exec: begin
                w_capture   = 1'b1;
                w_state_nxt = c_st_resp;
            end
            c_st_resp: begin
                if (rsp_ready[r_owner]) begin
                    w_release   = 1'b1;
                    w_state_nxt = c_st_idle;
                end
            end
            default: w_state_nxt = c_st_idle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= c_st_idle;
            r_owner      <= 1'b0;
            r_last_grant <= 1'b1;
            r_a          <= '0;
            r_b          <= '0;
            r_ctr        <= '0;
            rsp_result   <= '0;
            rsp_zero     <= 1'b0;
            rsp_overflow <= 1'b0;
            rsp_err      <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_load) begin
                r_owner      <= w_grant_id;
                r_last_grant <= w_grant_id;
                r_a          <= w_grant_id ? req1_a   : req0_a;
                r_b          <= w_grant_id ? req1_b   : req0_b;
                r_ctr        <= w_grant_id ? req1_ctr : req0_ctr;
            end
            if (w_capture) begin
                rsp_result   <= w_alu_result;
                rsp_zero     <= w_alu_zero;
                rsp_overflow <= w_alu_overflow;
                rsp_err      <= w_alu_err;
            end
        end
    end

    always_comb begin
        rsp_valid = 2'b00;
        if (r_state == c_st_resp) begin
            rsp_valid[r_owner] = 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_alu_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_arbiter
// Purpose  : Scoreboard bench for alu_arbiter using directed vectors.
// Revision : 1.0
// ============================================================================
module tb_alu_arbiter;

    typedef struct {
        logic        owner;
        logic [31:0] result;
        logic        zero;
        logic        ovf;
        logic        err;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  req_valid;
    logic [1:0]  req_ready;
    logic [31:0] req0_a, req0_b, req1_a, req1_b;
    logic [3:0]  req0_ctr, req1_ctr;
    logic [1:0]  rsp_valid;
    logic [1:0]  rsp_ready;
    logic [31:0] rsp_result;
    logic        rsp_zero, rsp_overflow, rsp_err;

    exp_t exp_q[$];
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    alu_arbiter dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req0_a       (req0_a),
        .req0_b       (req0_b),
        .req0_ctr     (req0_ctr),
        .req1_a       (req1_a),
        .req1_b       (req1_b),
        .req1_ctr     (req1_ctr),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_result   (rsp_result),
        .rsp_zero     (rsp_zero),
        .rsp_overflow (rsp_overflow),
        .rsp_err      (rsp_err)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    // Monitor: pops one expectation per completed response handshake
    always @(negedge clk) begin
        if (!rst && rsp_valid != 2'b00) begin
            if (rsp_valid != 2'b01 && rsp_valid != 2'b10) begin
                total++; bad++;
                $display("FAIL rsp_onehot: got %b", rsp_valid);
            end else if (rsp_ready[rsp_valid[1]]) begin
                total++;
                if (exp_q.size() == 0) begin
                    bad++;
                    $display("FAIL rsp_unexpected: valid=%b result=%h", rsp_valid, rsp_result);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    if (rsp_valid[1] !== e.owner || rsp_result !== e.result || rsp_zero !== e.zero
                        || rsp_overflow !== e.ovf || rsp_err !== e.err) begin
                        bad++;
                        $display("FAIL rsp_data: got own=%0d res=%h z=%b o=%b e=%b expected own=%0d res=%h z=%b o=%b e=%b",
                                 rsp_valid[1], rsp_result, rsp_zero, rsp_overflow, rsp_err,
                                 e.owner, e.result, e.zero, e.ovf, e.err);
                    end
                end
            end
        end
    end

    task automatic push(input logic own, input logic [31:0] r, input logic z, input logic o, input logic e);
        exp_t x;
        x.owner = own; x.result = r; x.zero = z; x.ovf = o; x.err = e;
        exp_q.push_back(x);
    endtask

    task automatic set_op(input int idx, input logic [31:0] a, input logic [31:0] b, input logic [3:0] ctr);
        if (idx == 0) begin req0_a = a; req0_b = b; req0_ctr = ctr; end
        else          begin req1_a = a; req1_b = b; req1_ctr = ctr; end
    endtask

    // Returns #1 after the edge on which requester idx was accepted
    task automatic wait_accept(input int idx);
        int n = 0;
        while (1) begin
            @(negedge clk);
            if (req_valid[idx] && req_ready[idx]) break;
            n++;
            if (n > 20) begin
                total++; bad++;
                $display("FAIL accept_timeout: req%0d ready=%b expected accept", idx, req_ready);
                break;
            end
        end
        @(posedge clk); #1;
    endtask

    task automatic wait_drain();
        int n = 0;
        while (exp_q.size() != 0) begin
            @(posedge clk); #2;
            n++;
            if (n > 30) begin
                total++; bad++;
                $display("FAIL drain_timeout: pending=%0d expected 0", exp_q.size());
                exp_q.delete();
            end
        end
    endtask

    task automatic do_op(input int idx, input logic [31:0] a, input logic [31:0] b, input logic [3:0] ctr,
                         input logic [31:0] r, input logic z, input logic o, input logic e);
        push(idx[0], r, z, o, e);
        set_op(idx, a, b, ctr);
        req_valid[idx] = 1'b1;
        wait_accept(idx);
        req_valid[idx] = 1'b0;
        wait_drain();
    endtask

    task automatic tie(input logic [31:0] a0, input logic [31:0] b0, input logic [3:0] c0, input logic [31:0] r0,
                       input logic [31:0] a1, input logic [31:0] b1, input logic [3:0] c1, input logic [31:0] r1);
        push(1'b0, r0, r0 == 0, 1'b0, 1'b0);
        push(1'b1, r1, r1 == 0, 1'b0, 1'b0);
        set_op(0, a0, b0, c0);
        set_op(1, a1, b1, c1);
        req_valid = 2'b11;
        wait_accept(0);
        req_valid[0] = 1'b0;
        wait_accept(1);
        req_valid[1] = 1'b0;
        wait_drain();
    endtask

    initial begin
        rst = 1'b1; req_valid = 2'b11; rsp_ready = 2'b11;
        set_op(0, 0, 0, 0); set_op(1, 0, 0, 0);
        @(negedge clk);
        check("ready_in_reset", {30'd0, req_ready}, 32'd0);
        @(negedge clk);
        check("reset_rsp_valid", {30'd0, rsp_valid}, 32'd0);
        check("reset_result", rsp_result, 32'd0);
        check("reset_flags", {29'd0, rsp_zero, rsp_overflow, rsp_err}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0; req_valid = 2'b00;

        // Round-robin: req0 first on the opening tie, then again after req1
        tie(32'd1, 32'd2, 4'b1110, 32'd3, 32'd9, 32'd4, 4'b0100, 32'd5);
        tie(32'hF0, 32'h3C, 4'b0010, 32'h30, 32'hF0, 32'h0F, 4'b0011, 32'hFF);

        do_op(0, 32'h7FFF_FFFF, 32'd1, 4'b1110, 32'h8000_0000, 1'b0, 1'b1, 1'b0);
        do_op(0, 32'h7FFF_FFFF, 32'd1, 4'b0001, 32'h8000_0000, 1'b0, 1'b0, 1'b0);
        do_op(1, 32'h8000_0000, 32'd1, 4'b0100, 32'h7FFF_FFFF, 1'b0, 1'b1, 1'b0);
        do_op(1, 32'd3, 32'd5, 4'b0101, 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0);
        do_op(0, 32'd4, 32'd1, 4'b1010, 32'h10, 1'b0, 1'b0, 1'b0);
        do_op(1, 32'd1, 32'h8000_0000, 4'b1000, 32'h4000_0000, 1'b0, 1'b0, 1'b0);
        do_op(0, 32'd0, 32'h1234, 4'b0110, 32'h1234_0000, 1'b0, 1'b0, 1'b0);

        // Zero result with two-cycle latency
        push(1'b1, 32'd0, 1'b1, 1'b0, 1'b0);
        set_op(1, 32'd5, 32'd5, 4'b0100);
        req_valid[1] = 1'b1;
        wait_accept(1);
        req_valid[1] = 1'b0;
        @(negedge clk);
        check("latency_n1", {30'd0, rsp_valid}, 32'd0);
        @(negedge clk);
        check("latency_n2", {30'd0, rsp_valid}, 32'b10);
        wait_drain();

        do_op(0, 32'd5, 32'd6, 4'b1111, 32'd0, 1'b1, 1'b0, 1'b1);
        do_op(0, 32'd3, 32'd5, 4'b0111, 32'd6, 1'b0, 1'b0, 1'b0);

        // Back-pressure: response held while requester 1 keeps asking
        rsp_ready = 2'b00;
        push(1'b1, 32'hF800_0000, 1'b0, 1'b0, 1'b0);
        set_op(1, 32'd4, 32'h8000_0000, 4'b1001);
        req_valid[1] = 1'b1;
        wait_accept(1);
        @(negedge clk);
        check("exec_ready", {30'd0, req_ready}, 32'd0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("hold_valid", {30'd0, rsp_valid}, 32'b10);
            check("hold_result", rsp_result, 32'hF800_0000);
            check("hold_ready", {30'd0, req_ready}, 32'd0);
        end
        @(posedge clk); #1;
        rsp_ready = 2'b01;
        @(negedge clk);
        check("nonowner_ignored", {30'd0, rsp_valid}, 32'b10);
        @(posedge clk); #1;
        rsp_ready = 2'b11;
        req_valid[1] = 1'b0;
        wait_drain();

        // Reset during EXEC aborts the operation
        set_op(0, 32'd7, 32'd8, 4'b1110);
        req_valid[0] = 1'b1;
        wait_accept(0);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        req_valid[0] = 1'b0;
        @(negedge clk);
        check("abort_valid", {30'd0, rsp_valid}, 32'd0);
        check("abort_result", rsp_result, 32'd0);
        check("abort_flags", {29'd0, rsp_zero, rsp_overflow, rsp_err}, 32'd0);
        repeat (3) @(negedge clk);
        check("abort_no_rsp", {30'd0, rsp_valid}, 32'd0);
        @(posedge clk); #1;
        tie(32'd10, 32'd3, 4'b0111, 32'd9, 32'd2, 32'd2, 4'b0001, 32'd4);

        repeat (3) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
